// File: rtl/payload_extractor.sv
// payload_extractor: strips a fixed HDR_BYTES header from 512-bit AXI-Stream
// packets and re-aligns the payload to lane 0. Optional: PAYLOAD_EXTRACTOR_DROP_CNT_EN.
module payload_extractor #(
    parameter int S_AXIS_DATA_WIDTH  = 512,
    parameter int M_AXIS_DATA_WIDTH  = 512,
    parameter int S_AXIS_TUSER_WIDTH = 128,
    parameter int M_AXIS_TUSER_WIDTH = 128,
    parameter int HDR_BYTES          = 42
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [31:0]                     drop_count
);

    localparam int DW = S_AXIS_DATA_WIDTH;
    localparam int KW = DW / 8;
    localparam int UW = S_AXIS_TUSER_WIDTH;
    localparam int O  = HDR_BYTES;
    localparam int R  = KW - O;

    typedef enum logic [1:0] {FIRST, STREAM, FLUSH} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   res_q, res_d;
    logic [6:0]      flen_q, flen_d;
    logic [UW-1:0]   user_q, user_d;
    logic [DW-1:0]   data_q, data_d;
    logic [KW-1:0]   keep_q, keep_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;

    logic            load;
    logic            acc;
    logic [6:0]      l_cnt;
    logic            l_le_o;
    logic [DW-1:0]   cur_hi;
    logic [DW-1:0]   joined;

    function automatic logic [KW-1:0] ones(input logic [6:0] n);
        logic [KW-1:0] m;
        m = '0;
        for (int i = 0; i < KW; i++) m[i] = (i < int'(n));
        return m;
    endfunction

    function automatic logic [DW-1:0] expand(input logic [KW-1:0] k);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < KW; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    assign load   = !valid_q || m_axis_tready;
    assign s_axis_tready = axis_resetn && load && (state_q != FLUSH);
    assign acc    = s_axis_tvalid && s_axis_tready;
    assign l_le_o = (l_cnt <= 7'(O));
    assign cur_hi = s_axis_tdata >> (8 * O);
    assign joined = res_q | (s_axis_tdata << (8 * R));

    // Byte count of the current input beat
    always_comb begin
        l_cnt = '0;
        for (int i = 0; i < KW; i++) l_cnt = l_cnt + {6'd0, s_axis_tkeep[i]};
    end

    // State and datapath registers
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= FIRST;
            res_q   <= '0;
            flen_q  <= '0;
            user_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flen_q  <= flen_d;
            user_q  <= user_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FIRST:   if (acc && !s_axis_tlast) state_d = STREAM;
            STREAM:  if (acc && s_axis_tlast) state_d = l_le_o ? FIRST : FLUSH;
            FLUSH:   if (load) state_d = FIRST;
            default: state_d = FIRST;
        endcase
    end

    // Output beat, residue and metadata updates
    always_comb begin
        res_d   = res_q;
        flen_d  = flen_q;
        user_d  = user_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q && !m_axis_tready;
        unique case (state_q)
            FIRST: begin
                if (acc) begin
                    res_d  = cur_hi;
                    user_d = {s_axis_tuser[UW-1:16],
                              s_axis_tuser[15:0] - 16'(O)};
                    if (s_axis_tlast && !l_le_o) begin
                        valid_d = 1'b1;
                        keep_d  = ones(l_cnt - 7'(O));
                        data_d  = cur_hi & expand(keep_d);
                        last_d  = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (acc) begin
                    res_d   = cur_hi;
                    valid_d = 1'b1;
                    if (s_axis_tlast && l_le_o) begin
                        keep_d = ones(7'(R) + l_cnt);
                        last_d = 1'b1;
                    end else begin
                        keep_d = '1;
                        last_d = 1'b0;
                    end
                    if (s_axis_tlast && !l_le_o) flen_d = l_cnt - 7'(O);
                    data_d = joined & expand(keep_d);
                end
            end
            FLUSH: begin
                if (load) begin
                    valid_d = 1'b1;
                    keep_d  = ones(flen_q);
                    data_d  = res_q & expand(keep_d);
                    last_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;

`ifdef PAYLOAD_EXTRACTOR_DROP_CNT_EN
    logic        drop;
    logic [31:0] drop_q;

    assign drop = acc && (state_q == FIRST) && s_axis_tlast && l_le_o;

    // Count header-only packets that produce no payload
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) drop_q <= '0;
        else if (drop)    drop_q <= drop_q + 32'd1;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_payload_extractor.sv
// tb_payload_extractor: directed and randomized packet tests for
// payload_extractor with a byte scoreboard and hand-computed checks.
module tb_payload_extractor;

    logic         clk = 1'b0;
    logic         axis_resetn = 1'b1;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic [127:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic [31:0]  drop_count;

    payload_extractor dut (
        .axis_aclk     (clk),
        .axis_resetn   (axis_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]   exp_bytes[$];
    int           exp_len[$];
    logic [127:0] exp_user[$];

    bit           rand_rdy = 1'b0;
    bit           mon_en = 1'b1;
    bit           in_pkt = 1'b0;
    int           rem = 0;
    logic [127:0] cur_user = '0;
    int           pkt_beats = 0;
    int           done_beats = 0;
    int           pkts_done = 0;
    int           last_keep_n = 0;
    logic [15:0]  last_len = '0;
    logic [7:0]   first_lane0 = '0;
    bit           stall_q = 1'b0;
    logic [511:0] snap_data = '0;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream ready: constant high or randomly throttled
    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Output monitor and scoreboard
    always @(negedge clk) begin
        if (!axis_resetn) begin
            in_pkt  = 1'b0;
            stall_q = 1'b0;
        end else if (mon_en) begin
            if (stall_q) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, snap_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (!in_pkt) begin
                    if (exp_len.size() == 0) begin
                        check("spurious", m_axis_tvalid, 0);
                    end else begin
                        rem       = exp_len.pop_front();
                        cur_user  = exp_user.pop_front();
                        in_pkt    = 1'b1;
                        pkt_beats = 0;
                    end
                end
                if (in_pkt) begin
                    logic [511:0] ed;
                    logic [63:0]  ek;
                    int n;
                    n  = (rem > 64) ? 64 : rem;
                    ed = '0;
                    ek = '0;
                    for (int k = 0; k < n; k++) begin
                        ed[8*k +: 8] = exp_bytes.pop_front();
                        ek[k] = 1'b1;
                    end
                    check("data", m_axis_tdata, ed);
                    check("keep", m_axis_tkeep, ek);
                    check("last", m_axis_tlast, rem <= 64);
                    check("user", m_axis_tuser, cur_user);
                    if (pkt_beats == 0) first_lane0 = m_axis_tdata[7:0];
                    last_keep_n = $countones(m_axis_tkeep);
                    last_len    = m_axis_tuser[15:0];
                    rem = rem - n;
                    pkt_beats++;
                    if (rem == 0) begin
                        in_pkt     = 1'b0;
                        done_beats = pkt_beats;
                        pkts_done++;
                    end
                end
            end
            stall_q   = m_axis_tvalid && !m_axis_tready;
            snap_data = m_axis_tdata;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic wait_accept();
        int t = 0;
        @(negedge clk);
        while (!s_axis_tready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!s_axis_tready) check("accept_tmo", s_axis_tready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input logic [7:0] base,
                            input bit gaps, input bit push,
                            input int max_b);
        int nb;
        int n;
        logic [511:0] d;
        logic [63:0]  kk;
        nb = (len + 63) / 64;
        if (max_b >= 0 && max_b < nb) nb = max_b;
        if (push && len > 42) begin
            exp_len.push_back(len - 42);
            exp_user.push_back({96'h0, 8'hD0, 8'h5A, 16'(len - 42)});
            for (int i = 42; i < len; i++) exp_bytes.push_back(8'(base + i));
        end
        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            n = (len - b * 64 > 64) ? 64 : len - b * 64;
            for (int k = 0; k < 64; k++) begin
                d[8*k +: 8] = (k < n) ? 8'(base + b * 64 + k) : 8'hA5;
                kk[k] = (k < n);
            end
            s_axis_tdata  = d;
            s_axis_tkeep  = kk;
            s_axis_tlast  = ((b + 1) * 64 >= len);
            s_axis_tuser  = (b == 0) ? {96'h0, 8'hD0, 8'h5A, 16'(len)}
                                     : {128{1'b1}};
            s_axis_tvalid = 1'b1;
            wait_accept();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_len.size() != 0 || in_pkt) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain", exp_len.size() + int'(in_pkt), 0);
        check("drain_bytes", exp_bytes.size(), 0);
    endtask

    initial begin
        int pd;
        #3 axis_resetn = 1'b0;
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_drop", drop_count, 0);
        check("rst_sready", s_axis_tready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        axis_resetn = 1'b1;
        @(posedge clk);
        #1;

        send_pkt(100, 8'h00, 1'b0, 1'b1, -1);
        drain();
        check("p100_beats", done_beats, 1);
        check("p100_keep", last_keep_n, 58);
        check("p100_len", last_len, 58);
        check("p100_lane0", first_lane0, 8'h2A);

        send_pkt(150, 8'h10, 1'b0, 1'b1, -1);
        drain();
        check("p150_beats", done_beats, 2);
        check("p150_keep", last_keep_n, 44);
        check("p150_len", last_len, 108);
        check("p150_lane0", first_lane0, 8'h3A);

        send_pkt(120, 8'h20, 1'b0, 1'b1, -1);
        @(negedge clk);
        check("flush_rdy_lo", s_axis_tready, 0);
        @(negedge clk);
        check("flush_rdy_hi", s_axis_tready, 1);
        @(posedge clk);
        #1;
        drain();
        check("p120_beats", done_beats, 2);
        check("p120_keep", last_keep_n, 14);
        check("p120_len", last_len, 78);

        send_pkt(50, 8'h40, 1'b0, 1'b1, -1);
        drain();
        check("p50_beats", done_beats, 1);
        check("p50_keep", last_keep_n, 8);
        check("p50_len", last_len, 8);
        check("p50_lane0", first_lane0, 8'h6A);

        pd = pkts_done;
        send_pkt(42, 8'h50, 1'b0, 1'b1, -1);
        repeat (4) @(posedge clk);
        #1;
        check("drop_noout", pkts_done, pd);
`ifdef PAYLOAD_EXTRACTOR_DROP_CNT_EN
        check("drop_cnt", drop_count, 1);
`else
        check("drop_cnt", drop_count, 0);
`endif

        pd = pkts_done;
        rand_rdy = 1'b1;
        for (int p = 0; p < 20; p++)
            send_pkt($urandom_range(43, 1500), 8'($urandom), 1'b1, 1'b1, -1);
        drain();
        rand_rdy = 1'b0;
        check("rand_pkts", pkts_done, pd + 20);

        mon_en = 1'b0;
        @(posedge clk);
        #1;
        send_pkt(200, 8'h77, 1'b0, 1'b0, 2);
        s_axis_tdata  = {64{8'hC3}};
        s_axis_tkeep  = '1;
        s_axis_tvalid = 1'b1;
        #2 axis_resetn = 1'b0;
        #1;
        check("mrst_tvalid", m_axis_tvalid, 0);
        check("mrst_tdata", m_axis_tdata, 0);
        check("mrst_tkeep", m_axis_tkeep, 0);
        check("mrst_tuser", m_axis_tuser, 0);
        check("mrst_tlast", m_axis_tlast, 0);
        check("mrst_drop", drop_count, 0);
        check("mrst_sready", s_axis_tready, 0);
        @(posedge clk);
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        axis_resetn = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(100, 8'h33, 1'b0, 1'b1, -1);
        drain();
        check("post_beats", done_beats, 1);
        check("post_keep", last_keep_n, 58);
        check("post_len", last_len, 58);
        check("post_lane0", first_lane0, 8'h5D);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/payload_extractor.md
# payload_extractor

Upstream feeder for the SHA-2 hash engine. It takes raw packets from the 512-bit NetFPGA AXI-Stream datapath and strips a fixed-length protocol header (Ethernet/IPv4/UDP, 42 bytes by default). It re-aligns the remaining payload so that payload byte 0 lands in lane 0 of the first beat, and corrects the metadata length. The output drives the padder's slave port directly, so only message bytes are hashed.

## Interface
Parameters:
- S_AXIS_DATA_WIDTH, 512: input data width; only 512 is supported (64 byte lanes).
- M_AXIS_DATA_WIDTH, 512: output data width; must equal S_AXIS_DATA_WIDTH.
- S_AXIS_TUSER_WIDTH, 128: input metadata width. tuser[15:0] is pkt_len in bytes; tuser[23:16] is src_port; tuser[31:24] is dst_port.
- M_AXIS_TUSER_WIDTH, 128: output metadata width.
- HDR_BYTES, 42: header bytes stripped per packet. Legal range is 1..63.

Ports:
- axis_aclk, input, 1: single clock.
- axis_resetn, input, 1: asynchronous, active-low reset.
- s_axis_tdata, input, 512: packet data. Byte k is tdata[8k+7:8k].
- s_axis_tkeep, input, 64: byte enables. All-ones on non-last beats; contiguous from bit 0 on the last beat.
- s_axis_tuser, input, 128: metadata. Sampled on the first beat only.
- s_axis_tvalid, input, 1: source valid.
- s_axis_tready, output, 1: sink ready.
- s_axis_tlast, input, 1: last beat of the packet.
- m_axis_tdata, output, 512: re-aligned payload.
- m_axis_tkeep, output, 64: contiguous byte enables, LSB-first.
- m_axis_tuser, output, 128: metadata with pkt_len reduced by HDR_BYTES. Held constant across the packet.
- m_axis_tvalid, output, 1: output valid.
- m_axis_tready, input, 1: downstream ready.
- m_axis_tlast, output, 1: last payload beat.
- drop_count, output, 32: count of dropped packets (see Configuration).

## Operation
Definitions:
- O = HDR_BYTES; R = 64-O (residue bytes per full beat).
- L = popcount(s_axis_tkeep) on the input last beat.

FSM states: FIRST, STREAM, FLUSH.
- FIRST (awaiting beat 0 of a packet):
  - Capture bytes O..63 into the residue register. Capture tuser, writing pkt_len = tuser[15:0]-O.
  - If tlast and L<=O: the packet is dropped. No output; drop_count increments; stay in FIRST.
  - If tlast and L>O: emit one beat with bytes O..L-1 in lanes 0..L-O-1, keep = L-O ones, tlast=1; stay in FIRST.
  - Otherwise go to STREAM.
- STREAM, on accepting beat n:
  - Output data = residue in lanes 0..R-1, plus input bytes 0..O-1 in lanes R..63. Equivalently (prev>>8O) | (cur<<8R).
  - Residue becomes the current bytes O..63.
  - If tlast and L<=O: the beat carries R+L bytes with tlast=1; go to FIRST.
  - If tlast and L>O: emit a full 64-byte beat with tlast=0; the residue holds L-O bytes; go to FLUSH.
- FLUSH: emit the residue with keep = L-O ones and tlast=1; then go to FIRST.
- Arithmetic:
  - pkt_len subtraction is 16-bit and is not checked against underflow (dropped packets never emit).
  - Lanes beyond keep are driven 0.

## Timing
- Reset: every state register returns to its reset value on axis_resetn low, asynchronously and immediately.
  - Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tuser=0, drop_count=0; state is FIRST; residue cleared.
  - s_axis_tready=0 while reset is asserted.
- Output stage: a single registered stage.
  - s_axis_tready = (!m_axis_tvalid || m_axis_tready) && state!=FLUSH.
  - An input beat is accepted on s_axis_tvalid && s_axis_tready.
- Latency: one cycle from the accepting edge to m_axis_tvalid.
  - The first output appears after input beat 1 is accepted, or after beat 0 when it is the last beat.
  - A FLUSH beat is loaded in the cycle after the final full beat is accepted by downstream.
- Throughput: one beat per cycle. There is at most one bubble per packet (the FLUSH case).
- Handshake:
  - m_axis_* is stable while m_axis_tvalid && !m_axis_tready.
  - tvalid never drops without a handshake.
- A new packet's FIRST beat may be accepted in the same cycle that the previous packet's tlast beat is sent.
- A drop consumes exactly one input cycle and has no output effect.
- Reset mid-packet: the partial packet is discarded; the next accepted beat is treated as FIRST.

## Configuration
- PAYLOAD_EXTRACTOR_DROP_CNT_EN:
  - Defined: drop_count is a 32-bit counter, incremented once per dropped packet, wrapping at 2^32-1 to 0.
  - Undefined: the counter logic is not built and drop_count is tied to 0. Drop behaviour is otherwise identical.

## Test plan
All tests use HDR_BYTES=42.
- 100-byte packet (beats: keep 64, 36): one output beat, keep=58 ones, tlast=1, pkt_len=58, lane 0 = input byte 42.
- 150-byte packet (64, 64, 22): two beats, keep 64 then 44, tlast on the 2nd, pkt_len=108, byte-exact payload.
- 120-byte packet (64, 56): a full 64-byte beat, then a FLUSH beat with keep=14 and tlast=1; s_axis_tready is low for the FLUSH cycle.
- Single-beat packets:
  - 50 bytes -> one beat, keep=8, tlast=1, pkt_len=8.
  - 42 bytes -> no output; drop_count=1 with the macro defined, 0 without.
- Back-to-back random packets (43..1500 bytes) with random m_axis_tready and s_axis_tvalid gaps:
  - Output equals a scoreboard of input bytes 42 and onward.
  - Output is held stable while stalled.
- Reset asserted during beat 2 of a 200-byte packet: all outputs go to 0 immediately; the next 100-byte packet is extracted correctly.
